// File: rtl/spi_regbank.sv
// spi_regbank: SPI mode-0 slave (MSB first) in front of a config/status register bank.
// Burst reads and writes auto-increment the address; each config write raises a one-clock pulse.
module spi_regbank #(
    parameter int               NUM_CFG    = 8,
    parameter int               NUM_STATUS = 4,
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] CFG_RST    = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ena,
    input  logic                          spi_cs_n,
    input  logic                          spi_clk,
    input  logic                          spi_mosi,
    output logic                          spi_miso,
    output logic [NUM_CFG*WIDTH-1:0]      config_regs,
    input  logic [NUM_STATUS*WIDTH-1:0]   status_in,
    output logic [NUM_CFG-1:0]            cfg_wr_pulse,
    output logic                          wr_err,
    output logic                          frame_active
);

    localparam int MAP_SIZE = NUM_CFG + NUM_STATUS;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CMD  = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] RD   = 2'd3;

    localparam logic [5:0] CMD_LAST  = 6'd7;
    localparam logic [5:0] WORD_LAST = 6'(WIDTH - 1);

    logic [WIDTH-1:0] cfg_mem [NUM_CFG];

    logic cs_n_p0, cs_n_p1, cs_n_p2;
    logic sclk_p0, sclk_p1, sclk_p2;
    logic mosi_p0, mosi_p1;

    logic [1:0]       state;
    logic [5:0]       bit_cnt;
    logic [6:0]       cmd_sr;
    logic [6:0]       addr;
    logic [WIDTH-1:0] shift_sr;

    logic             wr_vld_p1;
    logic [WIDTH-1:0] wr_word_p1;
    logic [6:0]       wr_addr_p1;

    logic             cs_fall, cs_rise, sclk_rise, sclk_fall, mosi_bit;
    logic [7:0]       cmd_next;
    logic [WIDTH-1:0] word_next;
    logic             wr_fire;

    // Address step: wraps at the end of the map, unmapped addresses run on to 127 and roll to 0.
    function automatic logic [6:0] next_addr(input logic [6:0] a);
        if (int'(a) < MAP_SIZE)
            return (int'(a) == MAP_SIZE - 1) ? 7'd0 : a + 7'd1;
        return a + 7'd1;
    endfunction

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] sr, input logic b);
        logic [WIDTH:0] t;
        t = {sr, b};
        return t[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] read_reg(input logic [6:0] a);
        logic [WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_CFG; i++)
            if (int'(a) == i) v = cfg_mem[i];
        for (int j = 0; j < NUM_STATUS; j++)
            if (int'(a) == NUM_CFG + j) v = status_in[j*WIDTH +: WIDTH];
        return v;
    endfunction

    // Stage p0/p1: two-flop synchronisers; p2 holds the previous synced value for edge detect.
    // CS flops reset to "asserted" so a frame cut by rst cannot restart until CS rises and falls again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_n_p0 <= 1'b0;
            cs_n_p1 <= 1'b0;
            cs_n_p2 <= 1'b0;
            sclk_p0 <= 1'b0;
            sclk_p1 <= 1'b0;
            sclk_p2 <= 1'b0;
            mosi_p0 <= 1'b0;
            mosi_p1 <= 1'b0;
        end else begin
            cs_n_p0 <= spi_cs_n;
            cs_n_p1 <= cs_n_p0;
            cs_n_p2 <= cs_n_p1;
            sclk_p0 <= spi_clk;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
            mosi_p0 <= spi_mosi;
            mosi_p1 <= mosi_p0;
        end
    end

    assign cs_fall   =  cs_n_p2 & ~cs_n_p1;
    assign cs_rise   = ~cs_n_p2 &  cs_n_p1;
    assign sclk_rise =  sclk_p1 & ~sclk_p2;
    assign sclk_fall = ~sclk_p1 &  sclk_p2;
    assign mosi_bit  =  mosi_p1;
    assign cmd_next  = {cmd_sr, mosi_bit};
    assign word_next = shift_in(shift_sr, mosi_bit);
    assign wr_fire   = (state == WR) && sclk_rise && (bit_cnt == WORD_LAST) && !cs_rise && !cs_fall;

    // Stage p1: frame FSM, shifting and address sequencing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            frame_active <= 1'b0;
            bit_cnt      <= '0;
            cmd_sr       <= '0;
            addr         <= '0;
            shift_sr     <= '0;
            spi_miso     <= 1'b0;
            wr_vld_p1    <= 1'b0;
        end else begin
            wr_vld_p1 <= 1'b0;
            if (cs_rise) begin
                state        <= IDLE;
                frame_active <= 1'b0;
                spi_miso     <= 1'b0;
            end else if (cs_fall) begin
                state        <= CMD;
                frame_active <= 1'b1;
                bit_cnt      <= '0;
                spi_miso     <= 1'b0;
            end else begin
                case (state)
                    IDLE: ;
                    CMD: begin
                        if (sclk_rise) begin
                            cmd_sr <= cmd_next[6:0];
                            if (bit_cnt == CMD_LAST) begin
                                bit_cnt <= '0;
                                addr    <= cmd_next[6:0];
                                if (cmd_next[7]) begin
                                    state <= WR;
                                end else begin
                                    state    <= RD;
                                    shift_sr <= read_reg(cmd_next[6:0]);
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 6'd1;
                            end
                        end
                    end
                    WR: begin
                        if (sclk_rise) begin
                            shift_sr <= word_next;
                            if (bit_cnt == WORD_LAST) begin
                                bit_cnt   <= '0;
                                wr_vld_p1 <= 1'b1;
                                addr      <= next_addr(addr);
                            end else begin
                                bit_cnt <= bit_cnt + 6'd1;
                            end
                        end
                    end
                    RD: begin
                        if (sclk_fall) begin
                            spi_miso <= shift_sr[WIDTH-1];
                            shift_sr <= shift_sr << 1;
                        end else if (sclk_rise) begin
                            if (bit_cnt == WORD_LAST) begin
                                bit_cnt  <= '0;
                                addr     <= next_addr(addr);
                                shift_sr <= read_reg(next_addr(addr));
                            end else begin
                                bit_cnt <= bit_cnt + 6'd1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            wr_word_p1 <= word_next;
            wr_addr_p1 <= addr;
        end
    end

    // Stage p2: commit a completed word, or flag it when the target is read-only or writes are off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CFG; i++)
                cfg_mem[i] <= CFG_RST;
            cfg_wr_pulse <= '0;
            wr_err       <= 1'b0;
        end else begin
            cfg_wr_pulse <= '0;
            wr_err       <= 1'b0;
            if (wr_vld_p1) begin
                if (ena && (int'(wr_addr_p1) < NUM_CFG)) begin
                    for (int i = 0; i < NUM_CFG; i++) begin
                        if (int'(wr_addr_p1) == i) begin
                            cfg_mem[i]      <= wr_word_p1;
                            cfg_wr_pulse[i] <= 1'b1;
                        end
                    end
                end else begin
                    wr_err <= 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CFG; g++) begin : g_pack
        assign config_regs[g*WIDTH +: WIDTH] = cfg_mem[g];
    end

endmodule

// File: tb/tb_spi_regbank.sv
// Bench for spi_regbank: directed SPI frames against an address-map model of the register bank,
// with a per-cycle monitor of pulses and idle outputs.
module tb_spi_regbank;

    localparam int         NC   = 8;
    localparam int         NS   = 4;
    localparam int         W    = 8;
    localparam logic [7:0] RSTV = 8'hA5;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        spi_cs_n;
    logic        spi_clk;
    logic        spi_mosi;
    logic        spi_miso;
    logic [63:0] config_regs;
    logic [31:0] status_in;
    logic [7:0]  cfg_wr_pulse;
    logic        wr_err;
    logic        frame_active;

    spi_regbank #(
        .NUM_CFG(NC), .NUM_STATUS(NS), .WIDTH(W), .CFG_RST(RSTV)
    ) dut (
        .clk(clk), .rst(rst), .ena(ena),
        .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .config_regs(config_regs), .status_in(status_in),
        .cfg_wr_pulse(cfg_wr_pulse), .wr_err(wr_err), .frame_active(frame_active)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_cfg [NC];
    logic [7:0] st [NS];
    int         exp_pulse [NC];
    int         obs_pulse [NC];
    int         exp_err;
    int         obs_err;
    logic       chk_en;
    logic [7:0] tx_words [4];
    logic [7:0] rx_log [4];
    logic       mid_chg_en;
    int         mid_reg [4];
    logic [7:0] mid_val [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
        end
    endtask

    task automatic pack_status();
        for (int j = 0; j < NS; j++) status_in[j*8 +: 8] = st[j];
    endtask

    function automatic logic [6:0] m_next(input logic [6:0] a);
        int n;
        n = int'(a) + 1;
        if (int'(a) < NC + NS) n = n % (NC + NS);
        else n = n % 128;
        return 7'(n);
    endfunction

    function automatic logic [7:0] m_read(input logic [6:0] a);
        int ai;
        ai = int'(a);
        if (ai < NC) return exp_cfg[ai];
        if (ai < NC + NS) return st[ai - NC];
        return 8'h00;
    endfunction

    function automatic logic [63:0] m_packed();
        logic [63:0] p;
        for (int i = 0; i < NC; i++) p[i*8 +: 8] = exp_cfg[i];
        return p;
    endfunction

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (cfg_wr_pulse != 8'd0 || wr_err) begin
                    check("pulse_exclusive", 64'($countones(cfg_wr_pulse) + int'(wr_err)), 64'd1);
                    for (int i = 0; i < NC; i++) if (cfg_wr_pulse[i]) obs_pulse[i]++;
                    if (wr_err) obs_err++;
                end
                if (chk_en) begin
                    check("idle_cfg", config_regs, m_packed());
                    check("idle_ctl", {53'd0, spi_miso, frame_active, cfg_wr_pulse, wr_err}, 64'd0);
                end
            end
        end
    endtask

    task automatic xfer(input logic [7:0] tx, input int nb, input int k, output logic [7:0] rx);
        rx = 8'h00;
        for (int b = 0; b < nb; b++) begin
            spi_mosi = tx[7-b];
            #60 spi_clk = 1'b1;
            rx = {rx[6:0], spi_miso};
            #60 spi_clk = 1'b0;
            if (mid_chg_en && k >= 0 && b == 3) begin
                st[mid_reg[k]] = mid_val[k];
                pack_status();
            end
        end
    endtask

    task automatic end_frame();
        #60 spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        repeat (12) @(posedge clk);
        chk_en = 1'b1;
        repeat (4) @(posedge clk);
        for (int i = 0; i < NC; i++) check("pulse_count", 64'(obs_pulse[i]), 64'(exp_pulse[i]));
        check("err_count", 64'(obs_err), 64'(exp_err));
    endtask

    task automatic frame(input logic [7:0] cmd, input int n, input int part_bits);
        logic [6:0] a;
        logic [7:0] rx;
        logic [7:0] want;
        int         nb;
        int         ai;
        a = cmd[6:0];
        chk_en = 1'b0;
        spi_cs_n = 1'b0;
        #60;
        xfer(cmd, 8, -1, rx);
        check("frame_active", {63'd0, frame_active}, 64'd1);
        for (int k = 0; k < n; k++) begin
            nb = (k == n - 1 && part_bits >= 0) ? part_bits : 8;
            want = m_read(a);
            xfer(tx_words[k], nb, k, rx);
            rx_log[k] = rx;
            if (nb == 8) begin
                ai = int'(a);
                if (cmd[7]) begin
                    if (ena && ai < NC) begin
                        exp_cfg[ai] = tx_words[k];
                        exp_pulse[ai]++;
                    end else begin
                        exp_err++;
                    end
                end else begin
                    check("read_word", {56'd0, rx}, {56'd0, want});
                end
                a = m_next(a);
            end
        end
        end_frame();
    endtask

    initial begin
        logic [7:0] rx;
        rst = 1'b1; ena = 1'b1;
        spi_cs_n = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
        chk_en = 1'b0; mid_chg_en = 1'b0;
        st[0] = 8'h10; st[1] = 8'h5A; st[2] = 8'hC3; st[3] = 8'h7E;
        pack_status();
        for (int i = 0; i < NC; i++) begin
            exp_cfg[i] = RSTV; exp_pulse[i] = 0; obs_pulse[i] = 0;
        end
        exp_err = 0; obs_err = 0;
        for (int i = 0; i < 4; i++) begin
            mid_reg[i] = 0; mid_val[i] = 8'h00; tx_words[i] = 8'h00; rx_log[i] = 8'h00;
        end
        fork
            monitor();
        join_none

        repeat (4) @(negedge clk);
        check("reset_cfg", config_regs, 64'hA5A5A5A5A5A5A5A5);
        rst = 1'b0;
        @(negedge clk);
        check("reset_ctl", {53'd0, spi_miso, frame_active, cfg_wr_pulse, wr_err}, 64'd0);
        chk_en = 1'b1;
        repeat (4) @(negedge clk);

        // Single write to reg3
        tx_words[0] = 8'h3C;
        frame(8'h83, 1, -1);
        check("wr_reg3", {56'd0, config_regs[31:24]}, 64'h3C);
        check("wr_reg3_pulse", 64'(obs_pulse[3]), 64'd1);
        check("wr_others", config_regs & ~64'h00000000FF000000, 64'hA5A5A5A5_00A5A5A5);

        // Burst write running into the status range
        tx_words[0] = 8'h11; tx_words[1] = 8'h22; tx_words[2] = 8'h33;
        frame(8'h86, 3, -1);
        check("burst_reg6", {56'd0, config_regs[55:48]}, 64'h11);
        check("burst_reg7", {56'd0, config_regs[63:56]}, 64'h22);
        check("burst_err", 64'(obs_err), 64'd1);

        // Status read with the source changing mid-word
        mid_chg_en = 1'b1;
        mid_reg[0] = 1; mid_val[0] = 8'hFF;
        mid_reg[1] = 2; mid_val[1] = 8'h00;
        tx_words[0] = 8'h00; tx_words[1] = 8'h00;
        frame(8'h09, 2, -1);
        mid_chg_en = 1'b0;
        check("rd_status1", {56'd0, rx_log[0]}, 64'h5A);
        check("rd_status2", {56'd0, rx_log[1]}, 64'hC3);

        // Write with ena low, then read back
        ena = 1'b0;
        tx_words[0] = 8'hFF;
        frame(8'h80, 1, -1);
        ena = 1'b1;
        check("ena0_err", 64'(obs_err), 64'd2);
        check("ena0_reg0", {56'd0, config_regs[7:0]}, 64'hA5);
        tx_words[0] = 8'h00;
        frame(8'h00, 1, -1);
        check("ena0_readback", {56'd0, rx_log[0]}, 64'hA5);

        // CS released after four data bits
        tx_words[0] = 8'h99;
        frame(8'h81, 1, 4);
        check("abort_reg1", {56'd0, config_regs[15:8]}, 64'hA5);
        check("abort_pulse", 64'(obs_pulse[1]), 64'd0);

        // rst in the middle of a write word; the rest of the frame must be ignored
        chk_en = 1'b0;
        spi_cs_n = 1'b0;
        #60;
        xfer(8'h82, 8, -1, rx);
        xfer(8'hF0, 4, -1, rx);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_cfg", config_regs, 64'hA5A5A5A5A5A5A5A5);
        rst = 1'b0;
        for (int i = 0; i < NC; i++) exp_cfg[i] = RSTV;
        xfer(8'hF0, 4, -1, rx);
        xfer(8'h77, 8, -1, rx);
        @(negedge clk);
        check("midrst_idle", {63'd0, frame_active}, 64'd0);
        end_frame();

        // Normal frame after the interrupted one
        tx_words[0] = 8'h5C;
        frame(8'h85, 1, -1);
        check("post_reg5", {56'd0, config_regs[47:40]}, 64'h5C);
        check("post_reg5_pulse", 64'(obs_pulse[5]), 64'd1);

        // Read across the map end wraps to address 0
        tx_words[0] = 8'h00; tx_words[1] = 8'h00;
        frame(8'h0B, 2, -1);
        check("wrap_status3", {56'd0, rx_log[0]}, 64'h7E);
        check("wrap_reg0", {56'd0, rx_log[1]}, 64'hA5);

        // Write starting at unmapped 127 rolls over into reg0
        tx_words[0] = 8'h12; tx_words[1] = 8'h34;
        frame(8'hFF, 2, -1);
        check("unmapped_reg0", {56'd0, config_regs[7:0]}, 64'h34);
        check("unmapped_err", 64'(obs_err), 64'd3);

        // Unmapped read returns zero, then wraps into reg0
        tx_words[0] = 8'h00; tx_words[1] = 8'h00; tx_words[2] = 8'h00;
        frame(8'h7E, 3, -1);
        check("unmapped_rd", {56'd0, rx_log[0]}, 64'h00);
        check("unmapped_rd_wrap", {56'd0, rx_log[2]}, 64'h34);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
